// File: rtl/rx_frame_timer_if.sv
// Bundle of control, configuration and timing signals between the RX
// front end (master) and the oversampling frame timer (slave).
interface rx_frame_timer_if #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
);
    logic               start;
    logic               abort;
    logic [PRESC_W-1:0] prescaler;
    logic [1:0]         data_len;
    logic               par_en;
    logic               stop2;
    logic               busy;
    logic [PRESC_W-1:0] edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [2:0]         samp_strb;
    logic               bit_done;
    logic               frame_done;

    modport master (
        output start, abort, prescaler, data_len, par_en, stop2,
        input  busy, edge_cnt, bit_cnt, samp_strb, bit_done, frame_done
    );

    modport slave (
        input  start, abort, prescaler, data_len, par_en, stop2,
        output busy, edge_cnt, bit_cnt, samp_strb, bit_done, frame_done
    );
endinterface

// File: rtl/rx_frame_timer.sv
// Oversampling timing engine for the UART receiver. Counts edges within a
// bit and bits within a frame, with the frame shape latched at start, and
// decodes mid-bit sample strobes plus bit/frame completion pulses.
module rx_frame_timer #(
    parameter int PRESC_W   = 6,
    parameter int BIT_W     = 4,
    parameter int MIN_PRESC = 4
) (
    input logic              CLK,
    input logic              RST,
    rx_frame_timer_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
    localparam logic [BIT_W-1:0]   B_ONE = BIT_W'(1);
    localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(MIN_PRESC);

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] edge_cnt, edge_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [PRESC_W-1:0] p_reg, p_nxt;
    logic [BIT_W-1:0]   l_reg, l_nxt;

    logic               run;
    logic               last_edge;
    logic               last_bit;
    logic [PRESC_W-1:0] mid;
    logic [PRESC_W-1:0] p_cfg;
    logic [BIT_W-1:0]   l_cfg;
    logic [2:0]         strb;
    logic               bit_done;
    logic               frame_done;

    // Frame shape as it would be latched by a start this cycle: clamped
    // oversampling ratio and total bit count (start + data + parity + stop).
    always_comb begin
        p_cfg = (bus.prescaler < P_MIN) ? P_MIN : bus.prescaler;
        l_cfg = BIT_W'(7) + BIT_W'(bus.data_len) + BIT_W'(bus.par_en) + BIT_W'(bus.stop2);
    end

    // Decodes of the registered counters; abort suppresses completion pulses.
    always_comb begin
        run        = (state == RUN);
        mid        = p_reg >> 1;
        last_edge  = (edge_cnt == p_reg - P_ONE);
        last_bit   = (bit_cnt == l_reg - B_ONE);
        bit_done   = run && last_edge && !bus.abort;
        frame_done = bit_done && last_bit;
        strb[0]    = run && (edge_cnt == mid - P_ONE);
        strb[1]    = run && (edge_cnt == mid);
        strb[2]    = run && (edge_cnt == mid + P_ONE);
    end

    // Next-state logic: idle waits for start, run counts edges and bits.
    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_cnt;
        bit_nxt   = bit_cnt;
        p_nxt     = p_reg;
        l_nxt     = l_reg;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = RUN;
                    p_nxt     = p_cfg;
                    l_nxt     = l_cfg;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end else if (last_edge) begin
                    edge_nxt = '0;
                    if (last_bit) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + B_ONE;
                    end
                end else begin
                    edge_nxt = edge_cnt + P_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // State, counter and latched-configuration registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_reg    <= '0;
            l_reg    <= '0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
            p_reg    <= p_nxt;
            l_reg    <= l_nxt;
        end
    end

    assign bus.busy       = run;
    assign bus.edge_cnt   = edge_cnt;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.samp_strb  = strb;
    assign bus.bit_done   = bit_done;
    assign bus.frame_done = frame_done;

endmodule
